// File: rtl/data_mem_responder.sv
// data_mem_responder: a word-addressed data RAM that answers load/store
// requests from the MEM stage over a valid/ready channel. Each request gets
// exactly one response after WAIT_STATES extra cycles. Misaligned and
// out-of-range accesses are flagged through resp_err.
// Optional feature macro: DMEM_BYTE_EN_EN adds the req_be port, which gives
// per-byte store masking.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_EN_EN
  input  logic [3:0]  req_be,
`endif
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // The last value the wait counter reaches before the FSM moves to RESP.
  // With zero wait states the WAIT state is never entered, so the value is unused.
  localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  // The memory is not reset. It starts at all zeros.
  logic [31:0] mem_q [DEPTH] = '{default: '0};

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
`ifdef DMEM_BYTE_EN_EN
  logic [3:0]  be_q, be_d;
  logic [3:0]  src_be;
`endif

  logic [31:0]           src_addr;
  logic [31:0]           src_wdata;
  logic                  src_write;
  logic                  src_err;
  logic [ADDR_WIDTH-1:0] src_idx;
  logic                  enter_resp;
  logic                  mem_we;
  logic [31:0]           mem_wdata;

  // Request that commits on the edge entering RESP. With zero wait states that edge is the accept edge, so the live inputs are used; otherwise the latched copy is used.
  always_comb begin
    src_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
    src_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    src_write = (state_q == ST_IDLE) ? req_write : write_q;
`ifdef DMEM_BYTE_EN_EN
    src_be    = (state_q == ST_IDLE) ? req_be    : be_q;
`endif
    src_idx   = src_addr[ADDR_WIDTH+1:2];
    src_err   = (src_addr[1:0] != 2'b00) || (src_addr[31:ADDR_WIDTH+2] != '0);
  end

  // Store data merge: only the enabled byte lanes replace the old word.
  always_comb begin
`ifdef DMEM_BYTE_EN_EN
    mem_wdata = mem_q[src_idx];
    for (int i = 0; i < 4; i++) begin
      if (src_be[i]) begin
        mem_wdata[8*i +: 8] = src_wdata[8*i +: 8];
      end
    end
`else
    mem_wdata = src_wdata;
`endif
  end

  // Next-state logic for the FSM, the request latch and the response registers.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
`ifdef DMEM_BYTE_EN_EN
    be_d         = be_q;
`endif
    rdata_d      = rdata_q;
    err_d        = err_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    enter_resp   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          write_d = req_write;
`ifdef DMEM_BYTE_EN_EN
          be_d    = req_be;
`endif
          if (WAIT_STATES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RESP: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b1;
        resp_rdata_d = rdata_q;
        resp_err_d   = err_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (enter_resp) begin
      err_d   = src_err;
      rdata_d = (src_write || src_err) ? 32'd0 : mem_q[src_idx];
    end

    req_ready_d = (state_d == ST_IDLE);
    mem_we      = enter_resp && src_write && !src_err;
  end

  // State and response registers. Reset drops any in-flight request before it commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
`ifdef DMEM_BYTE_EN_EN
      be_q         <= '0;
`endif
      rdata_q      <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
`ifdef DMEM_BYTE_EN_EN
      be_q         <= be_d;
`endif
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Array write port. A store that is interrupted by reset never reaches this point.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[src_idx] <= mem_wdata;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder. Instance a uses WAIT_STATES=2 and instance b
// uses WAIT_STATES=0. Both share the clock and reset. Expected values are
// worked out by hand. The byte-enable test is built only when DMEM_BYTE_EN_EN
// is defined.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic reset;

  logic        a_req_valid, a_req_write, a_req_ready, a_resp_valid, a_resp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic        b_req_valid, b_req_write, b_req_ready, b_resp_valid, b_resp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
`ifdef DMEM_BYTE_EN_EN
  logic [3:0]  a_req_be, b_req_be;
`endif

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  // Free-running clock and cycle counter used for latency measurement.
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(2)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .req_valid (a_req_valid),
    .req_write (a_req_write),
    .req_addr  (a_req_addr),
    .req_wdata (a_req_wdata),
`ifdef DMEM_BYTE_EN_EN
    .req_be    (a_req_be),
`endif
    .req_ready (a_req_ready),
    .resp_valid(a_resp_valid),
    .resp_rdata(a_resp_rdata),
    .resp_err  (a_resp_err)
  );

  data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .req_valid (b_req_valid),
    .req_write (b_req_write),
    .req_addr  (b_req_addr),
    .req_wdata (b_req_wdata),
`ifdef DMEM_BYTE_EN_EN
    .req_be    (b_req_be),
`endif
    .req_ready (b_req_ready),
    .resp_valid(b_resp_valid),
    .resp_rdata(b_resp_rdata),
    .resp_err  (b_resp_err)
  );

  // Single comparison point: counts the comparison and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one request and waits for its response. Checks the accept-to-response latency, the read data and the error flag.
  task automatic applyStimulus(input bit use_b, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input int exp_lat, input logic [31:0] exp_rdata,
                               input logic exp_err, input string tag,
                               output int accept_cycle);
    int   bound;
    int   lat;
    logic rdy;
    logic rv;
    $display("[TB] %s wr=%0d addr=0x%08h wdata=0x%08h be=%b", tag, wr, addr, wdata, be);
    if (use_b) begin
      b_req_valid = 1'b1; b_req_write = wr; b_req_addr = addr; b_req_wdata = wdata;
`ifdef DMEM_BYTE_EN_EN
      b_req_be = be;
`endif
    end else begin
      a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr; a_req_wdata = wdata;
`ifdef DMEM_BYTE_EN_EN
      a_req_be = be;
`endif
    end
    bound = 0;
    rdy   = use_b ? b_req_ready : a_req_ready;
    while (!rdy && bound < 20) begin
      @(posedge clk); #1;
      bound++;
      rdy = use_b ? b_req_ready : a_req_ready;
    end
    accept_cycle = -1;
    if (!rdy) begin
      checkOutput({tag, "_ready_timeout"}, {31'd0, rdy}, 32'd1);
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      accept_cycle = cycle;
      a_req_valid  = 1'b0;
      b_req_valid  = 1'b0;
      lat = 0;
      rv  = 1'b0;
      while (!rv && lat < 20) begin
        @(posedge clk); #1;
        lat++;
        rv = use_b ? b_resp_valid : a_resp_valid;
      end
      checkOutput({tag, "_latency"}, lat, exp_lat);
      checkOutput({tag, "_rdata"}, use_b ? b_resp_rdata : a_resp_rdata, exp_rdata);
      checkOutput({tag, "_err"}, {31'd0, use_b ? b_resp_err : a_resp_err}, {31'd0, exp_err});
    end
  endtask

  // Watchdog so the run always ends even if a wait somewhere misbehaves.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int acc1, acc2, acc_tmp;
    logic seen;
    reset       = 1'b1;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
`ifdef DMEM_BYTE_EN_EN
    a_req_be = 4'hF; b_req_be = 4'hF;
`endif
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready",      {31'd0, a_req_ready},  32'd0);
    checkOutput("rst_resp_valid", {31'd0, a_resp_valid}, 32'd0);
    checkOutput("rst_rdata",      a_resp_rdata,          32'd0);
    checkOutput("rst_err",        {31'd0, a_resp_err},   32'd0);
    checkOutput("rst_b_ready",    {31'd0, b_req_ready},  32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_ready",     {31'd0, a_req_ready},  32'd1);

    // Store to word 0, then read it back. The two accepts are WAIT_STATES+2 cycles apart.
    applyStimulus(0, 1'b1, 32'h0, 32'h3, 4'hF, 3, 32'h0, 1'b0, "t1_store", acc1);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'hF, 3, 32'h3, 1'b0, "t1_load",  acc2);
    checkOutput("t1_accept_spacing", acc2 - acc1, 32'd4);
    @(posedge clk); #1;
    checkOutput("t1_pulse_width", {31'd0, a_resp_valid}, 32'd0);
    checkOutput("t1_rdata_hold",  a_resp_rdata,          32'h3);

    // Store word 1. Word 3 is untouched and word 0 still holds 3.
    applyStimulus(0, 1'b1, 32'h4,  32'h7, 4'hF, 3, 32'h0, 1'b0, "t2_store",  acc_tmp);
    applyStimulus(0, 1'b0, 32'hC,  32'h0, 4'hF, 3, 32'h0, 1'b0, "t2_load_c", acc_tmp);
    applyStimulus(0, 1'b0, 32'h4,  32'h0, 4'hF, 3, 32'h7, 1'b0, "t2_load_4", acc_tmp);

    // Error cases: misaligned load, out-of-range store and out-of-range load.
    applyStimulus(0, 1'b0, 32'h2,   32'h0,  4'hF, 3, 32'h0, 1'b1, "t3_misalign", acc_tmp);
    @(posedge clk); #1;
    checkOutput("t3_err_hold",  {31'd0, a_resp_err},   32'd1);
    checkOutput("t3_valid_low", {31'd0, a_resp_valid}, 32'd0);
    applyStimulus(0, 1'b1, 32'h400, 32'h55, 4'hF, 3, 32'h0, 1'b1, "t3_oor_store", acc_tmp);
    applyStimulus(0, 1'b0, 32'h80000000, 32'h0, 4'hF, 3, 32'h0, 1'b1, "t3_oor_load", acc_tmp);
    applyStimulus(0, 1'b0, 32'h0,   32'h0,  4'hF, 3, 32'h3, 1'b0, "t3_word0",    acc_tmp);

    // Highest valid word.
    applyStimulus(0, 1'b1, 32'h3FC, 32'h12345678, 4'hF, 3, 32'h0,        1'b0, "bnd_store", acc_tmp);
    applyStimulus(0, 1'b0, 32'h3FC, 32'h0,        4'hF, 3, 32'h12345678, 1'b0, "bnd_load",  acc_tmp);
    applyStimulus(0, 1'b0, 32'h3F8, 32'h0,        4'hF, 3, 32'h0,        1'b0, "bnd_load2", acc_tmp);

    // Reset while a store is waiting. The store is dropped and no response is produced.
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h8; a_req_wdata = 32'hDEADBEEF;
`ifdef DMEM_BYTE_EN_EN
    a_req_be = 4'hF;
`endif
    checkOutput("t4_ready_pre", {31'd0, a_req_ready}, 32'd1);
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("t4_rdata_cleared", a_resp_rdata, 32'h0);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      seen = seen | a_resp_valid;
    end
    checkOutput("t4_no_resp", {31'd0, seen}, 32'd0);
    applyStimulus(0, 1'b0, 32'h8, 32'h0, 4'hF, 3, 32'h0, 1'b0, "t4_load8", acc_tmp);

    // Zero wait states, with req_valid held high across two back-to-back loads.
    applyStimulus(1, 1'b1, 32'h3FC, 32'hCAFE, 4'hF, 1, 32'h0, 1'b0, "t5_store", acc_tmp);
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 32'h3FC;
    checkOutput("t5_ready0", {31'd0, b_req_ready}, 32'd1);
    @(posedge clk); #1;
    checkOutput("t5_ready1", {31'd0, b_req_ready},  32'd0);
    checkOutput("t5_valid1", {31'd0, b_resp_valid}, 32'd0);
    b_req_addr = 32'h3F8;
    @(posedge clk); #1;
    checkOutput("t5_ready2", {31'd0, b_req_ready},  32'd1);
    checkOutput("t5_valid2", {31'd0, b_resp_valid}, 32'd1);
    checkOutput("t5_rdata2", b_resp_rdata,          32'hCAFE);
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    checkOutput("t5_ready3", {31'd0, b_req_ready},  32'd0);
    checkOutput("t5_valid3", {31'd0, b_resp_valid}, 32'd0);
    @(posedge clk); #1;
    checkOutput("t5_ready4", {31'd0, b_req_ready},  32'd1);
    checkOutput("t5_valid4", {31'd0, b_resp_valid}, 32'd1);
    checkOutput("t5_rdata4", b_resp_rdata,          32'h0);

`ifdef DMEM_BYTE_EN_EN
    // Byte-lane masked stores.
    applyStimulus(0, 1'b1, 32'h0, 32'h11223344, 4'hF,    3, 32'h0,        1'b0, "t6_full",   acc_tmp);
    applyStimulus(0, 1'b1, 32'h0, 32'hAABBCCDD, 4'b0101, 3, 32'h0,        1'b0, "t6_mask",   acc_tmp);
    applyStimulus(0, 1'b0, 32'h0, 32'h0,        4'b0000, 3, 32'h11BB33DD, 1'b0, "t6_load",   acc_tmp);
    applyStimulus(0, 1'b1, 32'h0, 32'hFFFFFFFF, 4'b0000, 3, 32'h0,        1'b0, "t6_nobe",   acc_tmp);
    applyStimulus(0, 1'b0, 32'h0, 32'h0,        4'hF,    3, 32'h11BB33DD, 1'b0, "t6_load2",  acc_tmp);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
